instr_mem_ctrl: RTL and testbench

- Parametrised instruction memory with a program-load port and a handshaked fetch interface.
- Replaces the fixed 256x32 combinational-read ROM.
- Adds a power-up clear sequence, registered (1-cycle) reads, valid/ready flow control with a 2-entry response buffer, and out-of-range detection.
- Sits between the fetch stage and the program loader / testbench.

---
 rtl/instr_mem_ctrl.sv | 86 ++++++++
 tb/tb_instr_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with power-up clear, load port and a
// valid/ready fetch path feeding a 2-entry in-order response buffer.
module instr_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instr,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err
);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_WORD);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] cnt, rd_addr, sk_addr;
  logic [DATA_W-1:0] rd_data, sk_instr;
  logic inflight, rd_err, sk_err, accept, push, pop, ld_ok;
  logic [1:0] count;
  always_comb begin
    state_nx = (state == CLEAR && cnt == LAST) ? RUN : state;
  end
  assign init_done = state == RUN;
  // no pop credit: a full buffer (including the read in flight) blocks new requests
  assign req_ready = init_done && !ld_en && (count + {1'b0, inflight}) < 2'd2;
  assign accept = req_valid && req_ready;
  assign ld_ok = init_done && ld_en && ({1'b0, ld_addr} < LIM);
  assign rd_err = !({1'b0, rd_addr} < LIM);
  assign rd_data = rd_err ? NOP : mem[rd_addr];
  assign push = inflight;
  assign pop = resp_valid && resp_ready;
  assign resp_valid = count != 2'd0;
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= NOP;
    else if (ld_ok) mem[ld_addr] <= ld_data;
  end
  // head of the buffer lives in the resp_* registers so they hold their last value when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      inflight <= 1'b0;
      rd_addr <= '0;
      count <= 2'd0;
      resp_instr <= '0;
      resp_addr <= '0;
      resp_err <= 1'b0;
      sk_instr <= '0;
      sk_addr <= '0;
      sk_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      inflight <= accept;
      if (accept) rd_addr <= req_addr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && (count == 2'd0 || pop)) begin
        resp_instr <= rd_data;
        resp_addr <= rd_addr;
        resp_err <= rd_err;
      end else if (push) begin
        sk_instr <= rd_data;
        sk_addr <= rd_addr;
        sk_err <= rd_err;
      end else if (pop && count == 2'd2) begin
        resp_instr <= sk_instr;
        resp_addr <= sk_addr;
        resp_err <= sk_err;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed and random fetch/load traffic against a queue-based reference model.
module tb_instr_mem_ctrl;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic ld_en = 0, req_valid = 0, resp_ready = 1;
  logic [7:0] ld_addr = 0, req_addr = 0;
  logic [31:0] ld_data = 0;
  logic init_done, req_ready, resp_valid, resp_err;
  logic [31:0] resp_instr;
  logic [7:0] resp_addr;
  logic ld_en2 = 0, req_valid2 = 0, resp_ready2 = 1;
  logic [7:0] ld_addr2 = 0, req_addr2 = 0;
  logic [31:0] ld_data2 = 0;
  logic init_done2, req_ready2, resp_valid2, resp_err2;
  logic [31:0] resp_instr2;
  logic [7:0] resp_addr2;
  typedef struct {logic [31:0] instr; logic [7:0] addr; logic err;} resp_t;
  resp_t exp_q[$];
  resp_t mon_e, mon_n;
  logic [31:0] mem_m [256];
  int checks = 0, errors = 0;

  instr_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .init_done(init_done), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_addr(resp_addr), .resp_err(resp_err));

  instr_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(200)) dut2 (
    .clk(clk), .rst(rst), .ld_en(ld_en2), .ld_addr(ld_addr2), .ld_data(ld_data2),
    .init_done(init_done2), .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_instr(resp_instr2),
    .resp_addr(resp_addr2), .resp_err(resp_err2));

  // scoreboard: expected response fixed at handshake time, loads applied once initialised
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got addr=%h instr=%h with no response outstanding", resp_addr, resp_instr);
        end else begin
          mon_e = exp_q.pop_front();
          if (resp_instr !== mon_e.instr || resp_addr !== mon_e.addr || resp_err !== mon_e.err) begin
            errors++;
            $display("FAIL sb_resp: got instr=%h addr=%h err=%b, expected instr=%h addr=%h err=%b",
                     resp_instr, resp_addr, resp_err, mon_e.instr, mon_e.addr, mon_e.err);
          end
        end
      end
      if (req_valid && req_ready) begin
        mon_n.instr = mem_m[req_addr];
        mon_n.addr = req_addr;
        mon_n.err = 1'b0;
        exp_q.push_back(mon_n);
      end
      if (ld_en && init_done) mem_m[ld_addr] = ld_data;
    end
  end

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(posedge clk); #1 ld_en = 0;
  endtask

  task automatic test_reset();
    int n = 0, n2 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({init_done, req_ready, resp_valid, resp_err} !== 4'b0 || resp_instr !== 32'h0 || resp_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: init_done=%b req_ready=%b resp_valid=%b instr=%h addr=%h err=%b, all zero required",
               init_done, req_ready, resp_valid, resp_instr, resp_addr, resp_err);
    end
    rst = 0;
    while (!init_done && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (init_done2 && n2 == 0) n2 = n;
    end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL init_cycles: got %0d, required 256", n); end
    checks++;
    if (n2 !== 200) begin errors++; $display("FAIL init_cycles_d200: got %0d, required 200", n2); end
    resp_ready = 1; req_valid = 1; req_addr = 8'h05;
    @(negedge clk);
    checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL idle_ready: got %b, required 1", req_ready); end
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1 || resp_instr !== NOP || resp_err !== 0 || resp_addr !== 8'h05) begin
      errors++;
      $display("FAIL cleared_read: got v=%b instr=%h addr=%h err=%b, required 1/%h/05/0", resp_valid, resp_instr, resp_addr, resp_err, NOP);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_fetch();
    load(8'h10, 32'hDEADBEEF);
    load(8'h11, 32'h00A00093);
    resp_ready = 1; req_valid = 1; req_addr = 8'h10;
    @(posedge clk); #1 req_addr = 8'h11;
    checks++;
    if (resp_valid !== 0) begin errors++; $display("FAIL lf_latency: resp_valid=%b one cycle early, required 0", resp_valid); end
    @(posedge clk); #1 req_valid = 0;
    checks++;
    if (resp_valid !== 1 || resp_addr !== 8'h10 || resp_instr !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lf_first: got v=%b addr=%h instr=%h, required 1/10/deadbeef", resp_valid, resp_addr, resp_instr);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1 || resp_addr !== 8'h11 || resp_instr !== 32'h00A00093) begin
      errors++;
      $display("FAIL lf_second: got v=%b addr=%h instr=%h, required 1/11/00a00093", resp_valid, resp_addr, resp_instr);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 0) begin errors++; $display("FAIL lf_empty: resp_valid=%b, required 0", resp_valid); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] h_instr;
    int acc = 0, n = 0;
    for (int i = 0; i < 4; i++) load(8'h20 + 8'(i), $urandom);
    resp_ready = 0; req_valid = 1; req_addr = 8'h20;
    repeat (6) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1 req_addr = 8'h20 + 8'(acc);
    end
    checks++;
    if (acc !== 2) begin errors++; $display("FAIL bp_accepted: got %0d, required 2", acc); end
    h_instr = resp_instr;
    checks++;
    if (req_ready !== 0 || resp_valid !== 1 || resp_addr !== 8'h20 || resp_instr !== mem_m[8'h20]) begin
      errors++;
      $display("FAIL bp_hold: got ready=%b v=%b addr=%h instr=%h, required 0/1/20/%h", req_ready, resp_valid, resp_addr, resp_instr, mem_m[8'h20]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1 || resp_addr !== 8'h20 || resp_instr !== h_instr) begin
      errors++;
      $display("FAIL bp_stable: got v=%b addr=%h instr=%h, required 1/20/%h", resp_valid, resp_addr, resp_instr, h_instr);
    end
    resp_ready = 1;
    while (acc < 4 && n < 50) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1 req_addr = 8'h20 + 8'(acc);
      req_valid = acc < 4;
      n++;
    end
    req_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (acc !== 4 || exp_q.size() !== 0 || resp_valid !== 0) begin
      errors++;
      $display("FAIL bp_drain: accepted=%0d pending=%0d v=%b, required 4/0/0", acc, exp_q.size(), resp_valid);
    end
  endtask

  task automatic test_ld_priority();
    logic [31:0] d;
    d = $urandom ^ NOP;
    resp_ready = 1; ld_en = 1; ld_addr = 8'h30; ld_data = d; req_valid = 1; req_addr = 8'h30;
    @(negedge clk);
    checks++;
    if (req_ready !== 0) begin errors++; $display("FAIL ldp_ready: got %b during load, required 0", req_ready); end
    @(posedge clk); #1 ld_en = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL ldp_ready_after: got %b, required 1", req_ready); end
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1 || resp_instr !== d || resp_addr !== 8'h30) begin
      errors++;
      $display("FAIL ldp_data: got v=%b addr=%h instr=%h, required 1/30/%h", resp_valid, resp_addr, resp_instr, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    ld_en2 = 1; ld_addr2 = 8'hC8; ld_data2 = 32'hCAFEF00D;
    @(posedge clk); #1 ld_addr2 = 8'hC7; ld_data2 = 32'h12345678;
    @(posedge clk); #1 ld_en2 = 0;
    resp_ready2 = 1; req_valid2 = 1; req_addr2 = 8'hC8;
    @(posedge clk); #1 req_addr2 = 8'hC7;
    @(posedge clk); #1 req_valid2 = 0;
    checks++;
    if (resp_valid2 !== 1 || resp_instr2 !== NOP || resp_err2 !== 1 || resp_addr2 !== 8'hC8) begin
      errors++;
      $display("FAIL oor_c8: got v=%b instr=%h addr=%h err=%b, required 1/%h/c8/1", resp_valid2, resp_instr2, resp_addr2, resp_err2, NOP);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid2 !== 1 || resp_instr2 !== 32'h12345678 || resp_err2 !== 0 || resp_addr2 !== 8'hC7) begin
      errors++;
      $display("FAIL oor_c7: got v=%b instr=%h addr=%h err=%b, required 1/12345678/c7/0", resp_valid2, resp_instr2, resp_addr2, resp_err2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr = 8'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 2) != 0);
      ld_en = ($urandom_range(0, 7) == 0);
      ld_addr = 8'($urandom_range(0, 15));
      ld_data = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 0; ld_en = 0; resp_ready = 1;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() !== 0 || resp_valid !== 0) begin
      errors++;
      $display("FAIL rnd_drain: pending=%0d v=%b, required 0/0", exp_q.size(), resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load(8'h10, 32'hDEADBEEF);
    resp_ready = 0; req_valid = 1; req_addr = 8'h10;
    repeat (4) @(posedge clk);
    #1 req_valid = 0;
    checks++;
    if (resp_valid !== 1 || req_ready !== 0 || resp_instr !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rm_prefill: got v=%b ready=%b instr=%h, required 1/0/deadbeef", resp_valid, req_ready, resp_instr);
    end
    rst = 1;
    foreach (mem_m[i]) mem_m[i] = NOP;
    #1;
    checks++;
    if (resp_valid !== 0 || init_done !== 0 || req_ready !== 0) begin
      errors++;
      $display("FAIL rm_async: got v=%b init_done=%b ready=%b, required 0/0/0", resp_valid, init_done, req_ready);
    end
    @(posedge clk); #1 rst = 0;
    resp_ready = 1;
    while (!init_done && n < 1000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL rm_init_cycles: got %0d, required 256", n); end
    req_valid = 1; req_addr = 8'h10;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1 || resp_instr !== NOP || resp_addr !== 8'h10) begin
      errors++;
      $display("FAIL rm_cleared: got v=%b addr=%h instr=%h, required 1/10/%h", resp_valid, resp_addr, resp_instr, NOP);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = NOP;
    test_reset();
    test_load_fetch();
    test_back_pressure();
    test_ld_priority();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
